// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, bus widths
// and the byte-lane merge used for partial stores.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Replace each byte lane of old_word whose strobe bit is set with the
  // corresponding lane of wdata.
  function automatic logic [WORD_W-1:0] merge_bytes(
    input logic [WORD_W-1:0] old_word,
    input logic [WORD_W-1:0] wdata,
    input logic [STRB_W-1:0] wstrb
  );
    logic [WORD_W-1:0] merged;
    merged = old_word;
    for (int unsigned i = 0; i < STRB_W; i++) begin
      if (wstrb[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32-bit word storage with asynchronous clear, per-byte write
// enables and an asynchronous read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 64,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [STRB_W-1:0] wr_be,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [WORD_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Clear every word on reset; otherwise merge enabled byte lanes into the word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (|wr_be) begin
      mem[wr_idx] <= merge_bytes(mem[wr_idx], wr_data, wr_be);
    end
  end

  assign rd_data = mem[rd_idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store at a time, executes it on an
// internal word array and responds a fixed LATENCY cycles after acceptance.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  input  logic [STRB_W-1:0] req_wstrb,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'((LATENCY >= 2) ? (LATENCY - 2) : 0);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              cap_write;
  logic [WORD_W-1:0] cap_addr;
  logic [WORD_W-1:0] cap_wdata;
  logic [STRB_W-1:0] cap_wstrb;

  logic              accept;
  logic              enter_resp;
  logic              exec_write;
  logic [WORD_W-1:0] exec_addr;
  logic [WORD_W-1:0] exec_wdata;
  logic [STRB_W-1:0] exec_wstrb;
  logic              exec_err;
  logic [STRB_W-1:0] wr_be;
  logic [WORD_W-1:0] rd_data;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign accept    = (state == IDLE) && req_valid;

  // With LATENCY==1 the access executes on the accept edge itself, before the
  // capture registers are loaded, so the live request fields are used then.
  assign exec_write = (state == IDLE) ? req_write : cap_write;
  assign exec_addr  = (state == IDLE) ? req_addr  : cap_addr;
  assign exec_wdata = (state == IDLE) ? req_wdata : cap_wdata;
  assign exec_wstrb = (state == IDLE) ? req_wstrb : cap_wstrb;

  assign exec_err   = (exec_addr[1:0] != 2'b00) ||
                      ({1'b0, exec_addr[WORD_W-1:2]} >= 31'(DEPTH));
  assign enter_resp = (state_nxt == RESP) && (state != RESP);
  assign wr_be      = (enter_resp && exec_write && !exec_err) ? exec_wstrb : '0;

  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .reset   (reset),
    .wr_be   (wr_be),
    .wr_idx  (exec_addr[2 +: IDX_W]),
    .wr_data (exec_wdata),
    .rd_idx  (exec_addr[2 +: IDX_W]),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (cnt == '0) state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and latency countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= '0;
    end else if (accept) begin
      cnt       <= CNT_INIT;
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
      cap_wstrb <= req_wstrb;
    end else if ((state == WAIT) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Response registers: loaded on entry to RESP, cleared on handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (enter_resp) begin
      rsp_rdata <= (!exec_write && !exec_err) ? rd_data : '0;
      rsp_err   <= exec_err;
    end else if ((state == RESP) && rsp_ready) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized
// traffic, compared every cycle against a transaction-level model.
module tb_dmem_responder;

  localparam int unsigned DEPTH   = 64;
  localparam int unsigned LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_wstrb (req_wstrb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] m_mem [DEPTH];
  bit          m_busy = 0;
  bit          m_resp = 0;
  logic [31:0] m_rdata = '0;
  bit          m_err = 0;
  int          m_cyc = 0;
  int          m_acc = 0;
  bit          m_w;
  logic [31:0] m_a, m_d;
  logic [3:0]  m_s;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      m_busy = 0; m_resp = 0; m_rdata = '0; m_err = 0; m_cyc = 0;
    end else begin
      m_cyc++;
      if (m_resp) begin
        if (rsp_ready) begin
          m_busy = 0; m_resp = 0; m_rdata = '0; m_err = 0;
        end
      end else if (!m_busy && req_valid) begin
        m_busy = 1; m_acc = m_cyc;
        m_w = req_write; m_a = req_addr; m_d = req_wdata; m_s = req_wstrb;
      end
      // The response becomes visible in the LATENCY-th cycle counted from the accept edge.
      if (m_busy && !m_resp && (m_cyc - m_acc == int'(LATENCY) - 1)) begin
        m_resp = 1;
        m_err  = (m_a % 4 != 0) || ((m_a / 4) >= DEPTH);
        m_rdata = '0;
        if (!m_err) begin
          if (m_w) begin
            for (int i = 0; i < 4; i++)
              if (m_s[i]) m_mem[m_a / 4][8*i +: 8] = m_d[8*i +: 8];
          end else begin
            m_rdata = m_mem[m_a / 4];
          end
        end
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      chk("req_ready", 32'(req_ready), 32'(!m_busy));
      chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err",   32'(rsp_err),   32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int unsigned rdly, input bit hold_req,
                     output logic [31:0] rd, output logic er, output int lat);
    int n;
    rd = '0; er = 1'b0; lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
    rsp_ready = (rdly == 0);
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      chk("accept_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    if (hold_req) begin
      req_write = 1'b1; req_addr = '0; req_wdata = 32'hFFFF_FFFF; req_wstrb = 4'hF;
    end else begin
      req_valid = 1'b0;
    end
    lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      chk("rsp_timeout", 32'(rsp_valid), 32'd1);
      req_valid = 1'b0; rsp_ready = 1'b1;
      return;
    end
    rd = rsp_rdata; er = rsp_err;
    for (int unsigned k = 0; k < rdly; k++) begin
      @(negedge clk);
      if (hold_req) chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rdata_stable", rsp_rdata, rd);
      chk("bp_valid_stable", 32'(rsp_valid), 32'd1);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (rdly != 0) chk("ready_after_release", 32'(req_ready), 32'd1);
    rsp_ready = 1'($urandom_range(0, 1));
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata",     rsp_rdata,      32'd0);
    chk("rst_err",       32'(rsp_err),   32'd0);

    txn(1'b0, 32'h10, '0, 4'h0, 0, 0, rd, er, lat);
    chk("load_cleared", rd, 32'h0);
    chk("load_cleared_err", 32'(er), 32'd0);

    txn(1'b1, 32'h8, 32'hDEAD_BEEF, 4'hF, 0, 0, rd, er, lat);
    chk("store_latency", 32'(lat), 32'(LATENCY));
    chk("store_err", 32'(er), 32'd0);
    chk("store_rdata", rd, 32'h0);
    txn(1'b0, 32'h8, '0, 4'h0, 0, 0, rd, er, lat);
    chk("load_full", rd, 32'hDEAD_BEEF);

    txn(1'b1, 32'h8, 32'h1122_3344, 4'b0101, 0, 0, rd, er, lat);
    txn(1'b0, 32'h8, '0, 4'h0, 0, 0, rd, er, lat);
    chk("load_strobed", rd, 32'hDE22_BE44);
    chk("model_strobed", m_mem[2], 32'hDE22_BE44);

    txn(1'b1, 32'h8, 32'h5555_5555, 4'h0, 0, 0, rd, er, lat);
    chk("zero_strb_err", 32'(er), 32'd0);
    txn(1'b0, 32'h8, '0, 4'h0, 0, 0, rd, er, lat);
    chk("zero_strb_unchanged", rd, 32'hDE22_BE44);

    txn(1'b1, 32'h0, 32'h1234_5678, 4'hF, 0, 0, rd, er, lat);
    txn(1'b0, 32'h6, '0, 4'h0, 0, 0, rd, er, lat);
    chk("misaligned_err", 32'(er), 32'd1);
    chk("misaligned_rdata", rd, 32'h0);
    txn(1'b1, 32'h100, 32'hCAFE_F00D, 4'hF, 0, 0, rd, er, lat);
    chk("range_err", 32'(er), 32'd1);
    txn(1'b0, 32'h0, '0, 4'h0, 0, 0, rd, er, lat);
    chk("no_alias", rd, 32'h1234_5678);

    // Backpressure with a competing store held on the request port.
    txn(1'b0, 32'h0, '0, 4'h0, 5, 1, rd, er, lat);
    chk("bp_rdata", rd, 32'h1234_5678);
    txn(1'b0, 32'h0, '0, 4'h0, 0, 0, rd, er, lat);
    chk("bp_store_dropped", rd, 32'h1234_5678);

    // Reset during WAIT abandons the store.
    @(negedge clk);
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h4; req_wdata = 32'hAA; req_wstrb = 4'hF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    txn(1'b0, 32'h4, '0, 4'h0, 0, 0, rd, er, lat);
    chk("midrst_no_commit", rd, 32'h0);

    // Randomized traffic, focused on a small address window to force reuse.
    for (int t = 0; t < 200; t++) begin
      int unsigned sel;
      logic [31:0] a;
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = 32'($urandom_range(0, 15)) << 2;
      else if (sel == 6) a = (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
      else if (sel == 7) a = 32'(DEPTH + $urandom_range(0, 1000)) << 2;
      else if (sel == 8) a = 32'h8000_0000 | (32'($urandom_range(0, DEPTH - 1)) << 2);
      else               a = 32'($urandom_range(0, DEPTH - 1)) << 2;
      txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
          $urandom_range(0, 3), bit'($urandom_range(0, 1)), rd, er, lat);
      chk("rand_latency", 32'(lat), 32'(LATENCY));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder on the far side of the core's load/store request/response interface.
- Accepts one load or store request at a time over a valid/ready handshake and performs it on an internal word array.
- Returns a response after a fixed, parameterised latency, with an error flag.
- Replaces the single-cycle combinational data-memory path when the core moves to multi-cycle memory access.

Parameters:
- DEPTH, 64, number of 32-bit words; power of two, >= 2.
- LATENCY, 2, cycles from the request-accept edge to rsp_valid assertion; integer >= 1.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset; asserted when 0.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte-lane enables for stores; bit i covers wdata[8i+7:8i].
- rsp_valid  output  1  response present.
- rsp_ready  input  1  requester accepts the response.
- rsp_rdata  output  32  load data; 0 for stores and errors.
- rsp_err  output  1  access error (misaligned or out of range).

Behaviour:
- Reset (reset==0, asynchronous):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - All DEPTH words cleared to 0.
  - A reset mid-transaction abandons it: no write commits and no response is issued.
- States: IDLE, WAIT, RESP.
  - req_ready = (state==IDLE). It is a registered state decode, not combinational from req_valid.
  - rsp_valid = (state==RESP).
- IDLE:
  - On req_valid && req_ready, capture req_write, req_addr, req_wdata, req_wstrb.
  - If LATENCY==1, go to RESP; otherwise go to WAIT with counter=LATENCY-2.
- WAIT:
  - If counter==0, go to RESP; otherwise decrement the counter.
  - Request inputs are ignored (req_ready=0).
- Execute on the edge entering RESP:
  - err = (addr[1:0]!=0) || (addr[31:2] >= DEPTH).
  - Load, no err: rsp_rdata = mem[addr[2+:log2(DEPTH)]].
  - Store, no err: each lane with wstrb[i]=1 is written; other lanes are unchanged; rsp_rdata=0.
  - Store with wstrb=0: no change, rsp_err=0.
  - Any err: no memory change, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid, rsp_rdata and rsp_err are held stable until rsp_ready==1.
  - On rsp_valid && rsp_ready, go to IDLE and clear rsp_rdata and rsp_err to 0.
  - No same-cycle turnaround: the next request can be accepted at the earliest in the cycle after the handshake.
- Latency: rsp_valid rises exactly LATENCY cycles after the accept edge.
  - Minimum request-to-request spacing is LATENCY+1 cycles with rsp_ready tied to 1.
- Ordering:
  - Strictly one outstanding transaction.
  - A load issued after a store's response handshake observes the stored data.
- Address bits above the index are checked for range and never aliased.
- rsp_ready held high while not in RESP has no effect.

Decomposition:
- Shared package dmem_pkg:
  - state encoding enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - WORD_W=32, STRB_W=4;
  - function for the byte-lane merge (old word, wdata, wstrb -> new word).
- One natural sub-module, dmem_array:
  - DEPTH x 32 storage with async clear and a per-byte write-enable port;
  - asynchronous read of the indexed word.
- FSM, latency counter and error check remain in dmem_responder.

Test Plan:
- Reset and idle check: assert reset=0 for 3 cycles, then release -> req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0; a load of 0x0000_0010 returns 0 with rsp_err=0.
- Store/load and latency (LATENCY=2, rsp_ready=1):
  - Store 0xDEAD_BEEF to 0x0000_0008 with wstrb=4'hF -> rsp_valid exactly 2 cycles after the accept edge, rsp_err=0.
  - Load from 0x0000_0008 -> rsp_rdata=0xDEAD_BEEF.
- Byte strobes:
  - Store 0xDEAD_BEEF to 0x0000_0008, then store 0x1122_3344 to 0x0000_0008 with wstrb=4'b0101.
  - Load from 0x0000_0008 -> 0xDE22_BE44.
- Errors:
  - Load from 0x0000_0006 -> rsp_err=1, rsp_rdata=0.
  - Store to 0x0000_0100 (word 64, DEPTH=64) -> rsp_err=1.
  - Load from 0x0000_0000 afterwards -> value unchanged.
- Backpressure: hold rsp_ready=0 for 5 cycles during a load -> rsp_valid and rsp_rdata stable throughout, req_ready=0, and a second req_valid is not accepted; releasing rsp_ready gives req_ready=1 in the following cycle.
- Reset mid-operation: accept a store of 0x0000_00AA to 0x0000_0004, then assert reset=0 while in WAIT -> after release, rsp_valid=0 and a load from 0x0000_0004 returns 0.
